triangle_raster_scanner: RTL
============================

Name: triangle_raster_scanner

Overview:
- Sequencer that walks the screen-space bounding box of one triangle and drives pixel coordinates into the combinational per-pixel rasterizer datapath.
- Collects each covered pixel's colour and depth from that datapath and streams them to the framebuffer/depth stage over a valid/ready interface.
- Sits between triangle setup (vertex transform output) and the framebuffer writer. Accepts one triangle at a time.

Parameters:
- WIDTH, 160, screen width in pixels; x is clamped to [0, WIDTH-1].
- HEIGHT, 120, screen height in pixels; y is clamped to [0, HEIGHT-1].

Ports:
- i_clk  in  1  clock; all logic on rising edge.
- i_reset_n  in  1  synchronous active-low reset.
- i_start  in  1  pulse: latch triangle and begin; ignored unless idle.
- i_v1, i_v2, i_v3  in  Vector4_t  screen-space vertices (FixedPoint x,y,z,w).
- i_c1, i_c2, i_c3  in  Vector4_t  RGBA vertex colours.
- o_busy  out  1  high in every state except IDLE.
- o_done  out  1  one-cycle pulse when the triangle is finished.
- o_px_x, o_px_y  out  32 signed  integer pixel coordinate driven to the datapath.
- o_v1..o_v3, o_c1..o_c3  out  Vector4_t  latched triangle driven to the datapath.
- i_px_write  in  1  datapath coverage flag for (o_px_x, o_px_y).
- i_px_colour  in  Vector4_t  datapath interpolated colour.
- i_px_z  in  FixedPoint_t  datapath interpolated z.
- o_valid  out  1  output pixel valid.
- i_ready  in  1  downstream accepts the pixel.
- o_x, o_y  out  32 signed  output pixel coordinate.
- o_colour  out  Vector4_t  output pixel colour.
- o_z  out  FixedPoint_t  output pixel depth.

Behaviour:
- Reset (i_reset_n low at edge): state IDLE. o_busy, o_done, o_valid, o_px_x, o_px_y, o_x, o_y, o_colour, o_z and latched vertices/colours are all 0. Reset mid-triangle abandons it; no o_done is issued.
- States: IDLE, SETUP, SCAN, DRAIN, DONE.
- IDLE: on i_start, latch i_v*/i_c* and go to SETUP.
- SETUP (1 cycle):
  - Integer part of each vertex x,y = arithmetic shift right by the FixedPoint fractional bit count (floor).
  - Bounding box xmin/xmax/ymin/ymax is the min/max of the three integer parts.
  - Clamp the box to the screen bounds.
  - If xmin > xmax or ymin > ymax after clamping (triangle off-screen), go to DONE.
  - Otherwise set cur = (xmin, ymin) and go to SCAN.
- SCAN:
  - o_px_x/o_px_y = cur, registered.
  - Output slot is free when !o_valid or i_ready.
  - If the slot is free:
    - If i_px_write: load o_x/o_y = cur, o_colour = i_px_colour, o_z = i_px_z, and set o_valid = 1.
    - Otherwise clear o_valid.
    - Then advance: x++ ; at xmax, wrap x to xmin and y++.
  - If the slot is not free, hold cur and all outputs (stall).
  - Advancing past (xmax, ymax) goes to DRAIN.
- DRAIN: stay until the slot is free; clear o_valid on that cycle and go to DONE.
- DONE: o_done = 1 for exactly one cycle, then IDLE.
- Timing and ordering:
  - i_start at cycle N gives SETUP at N+1 and the first coordinate at N+2.
  - A covered pixel is o_valid from N+3.
  - Throughput is 1 pixel/cycle with i_ready held high.
  - Scan order is raster order: y outer, x inner, ascending.
- o_valid/o_x/o_y/o_colour/o_z are stable while o_valid && !i_ready.
- o_done never coincides with o_valid = 1.
- i_start while busy has no effect.

Optional Feature:
- Macro TRIANGLE_RASTER_SCANNER_BACKFACE_CULL_EN.
- When defined, SETUP computes the signed area edge(v1,v2,v3) = (x2-x1)(y3-y1) - (y2-y1)(x3-x1) using FixedPoint multiply/sub. If area <= 0, the triangle goes directly to DONE: no SCAN cycles and zero pixels, with o_done at N+2.
- When undefined, no area check is made and every triangle is scanned in full.

Test Plan:
- v1=(0,0), v2=(3,0), v3=(0,3), i_ready=1 -> 10 pixels in order (0,0)(1,0)(2,0)(3,0)(0,1)(1,1)(2,1)(0,2)(1,2)(0,3); first o_valid at N+3; o_done at N+19; never o_valid with o_done.
- Same triangle, i_ready low for 3 cycles at pixel 2 -> pixel (1,0) held stable for 4 cycles; sequence and count unchanged; o_done delayed by 3 cycles.
- Clockwise triangle v2 and v3 swapped -> macro off: 0 pixels, o_done at N+19; macro on: 0 pixels, o_done at N+2.
- Triangle (-5,-5),(-1,-5),(-5,-1) -> off-screen: o_done at N+2, no o_valid.
- Triangle (150,110),(170,110),(150,130) with WIDTH=160, HEIGHT=120 -> scan box x 150..159, y 110..119; no o_x >= 160 or o_y >= 120.
- i_reset_n low mid-SCAN -> next cycle o_busy=o_valid=o_done=0; a new i_start restarts cleanly.

Source files
------------

// File: rtl/triangle_raster_scanner_pkg.sv
// Fixed-point and vector payload types shared by the triangle raster scanner and its environment.
package triangle_raster_scanner_pkg;

  localparam int unsigned FP_W    = 32;
  localparam int unsigned FP_FRAC = 16;

  typedef logic signed [FP_W-1:0] FixedPoint_t;

  typedef struct packed {
    FixedPoint_t x;
    FixedPoint_t y;
    FixedPoint_t z;
    FixedPoint_t w;
  } Vector4_t;

endpackage

// File: rtl/triangle_raster_scanner.sv
// Walks one triangle's clamped bounding box in raster order and streams covered pixels downstream.
// Optional macro TRIANGLE_RASTER_SCANNER_BACKFACE_CULL_EN drops triangles with non-positive area in SETUP.
module triangle_raster_scanner
  import triangle_raster_scanner_pkg::*;
#(
  parameter int unsigned WIDTH  = 160,
  parameter int unsigned HEIGHT = 120
) (
  input  logic               i_clk,
  input  logic               i_reset_n,
  input  logic               i_start,
  input  Vector4_t           i_v1,
  input  Vector4_t           i_v2,
  input  Vector4_t           i_v3,
  input  Vector4_t           i_c1,
  input  Vector4_t           i_c2,
  input  Vector4_t           i_c3,
  output logic               o_busy,
  output logic               o_done,
  output logic signed [31:0] o_px_x,
  output logic signed [31:0] o_px_y,
  output Vector4_t           o_v1,
  output Vector4_t           o_v2,
  output Vector4_t           o_v3,
  output Vector4_t           o_c1,
  output Vector4_t           o_c2,
  output Vector4_t           o_c3,
  input  logic               i_px_write,
  input  Vector4_t           i_px_colour,
  input  FixedPoint_t        i_px_z,
  output logic               o_valid,
  input  logic               i_ready,
  output logic signed [31:0] o_x,
  output logic signed [31:0] o_y,
  output Vector4_t           o_colour,
  output FixedPoint_t        o_z
);

  typedef logic signed [31:0] coord_t;

  localparam coord_t X_LAST = coord_t'(WIDTH - 1);
  localparam coord_t Y_LAST = coord_t'(HEIGHT - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SETUP = 3'd1;
  localparam logic [2:0] S_SCAN  = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  function automatic coord_t int_part(input FixedPoint_t v);
    return coord_t'(v >>> FP_FRAC);
  endfunction

  function automatic coord_t min3(input coord_t a, input coord_t b, input coord_t c);
    coord_t m;
    m = (a < b) ? a : b;
    return (c < m) ? c : m;
  endfunction

  function automatic coord_t max3(input coord_t a, input coord_t b, input coord_t c);
    coord_t m;
    m = (a > b) ? a : b;
    return (c > m) ? c : m;
  endfunction

  logic [2:0] state, state_nxt;
  coord_t     xmin, xmax, ymax;
  coord_t     xmin_nxt, xmax_nxt, ymax_nxt;
  coord_t     px_x_nxt, px_y_nxt, x_nxt, y_nxt;
  Vector4_t   v1_nxt, v2_nxt, v3_nxt, c1_nxt, c2_nxt, c3_nxt, colour_nxt;
  FixedPoint_t z_nxt;
  logic       valid_nxt, busy_nxt, done_nxt;

  coord_t     x1, x2, x3, y1, y2, y3;
  coord_t     bx_lo, bx_hi, by_lo, by_hi;
  logic       box_empty;
  logic       cull;
  logic       slot_free;

  // Integer bounding box of the latched triangle; each side clamped only toward the screen.
  always_comb begin
    x1 = int_part(o_v1.x);
    x2 = int_part(o_v2.x);
    x3 = int_part(o_v3.x);
    y1 = int_part(o_v1.y);
    y2 = int_part(o_v2.y);
    y3 = int_part(o_v3.y);
    bx_lo = min3(x1, x2, x3);
    bx_hi = max3(x1, x2, x3);
    by_lo = min3(y1, y2, y3);
    by_hi = max3(y1, y2, y3);
    if (bx_lo < 32'sd0)  bx_lo = 32'sd0;
    if (bx_hi > X_LAST)  bx_hi = X_LAST;
    if (by_lo < 32'sd0)  by_lo = 32'sd0;
    if (by_hi > Y_LAST)  by_hi = Y_LAST;
    box_empty = (bx_lo > bx_hi) || (by_lo > by_hi);
  end

`ifdef TRIANGLE_RASTER_SCANNER_BACKFACE_CULL_EN
  logic signed [32:0] e1x, e1y, e2x, e2y;
  logic signed [65:0] area;

  // Full-precision signed area; only its sign matters, so no rescaling is needed.
  always_comb begin
    e1x  = 33'(o_v2.x) - 33'(o_v1.x);
    e1y  = 33'(o_v2.y) - 33'(o_v1.y);
    e2x  = 33'(o_v3.x) - 33'(o_v1.x);
    e2y  = 33'(o_v3.y) - 33'(o_v1.y);
    area = 66'(e1x) * 66'(e2y) - 66'(e1y) * 66'(e2x);
    cull = (area <= 66'sd0);
  end
`else
  assign cull = 1'b0;
`endif

  assign slot_free = !o_valid || i_ready;

  // Next-state and next-output logic.
  always_comb begin
    state_nxt  = state;
    v1_nxt     = o_v1;
    v2_nxt     = o_v2;
    v3_nxt     = o_v3;
    c1_nxt     = o_c1;
    c2_nxt     = o_c2;
    c3_nxt     = o_c3;
    xmin_nxt   = xmin;
    xmax_nxt   = xmax;
    ymax_nxt   = ymax;
    px_x_nxt   = o_px_x;
    px_y_nxt   = o_px_y;
    valid_nxt  = o_valid;
    x_nxt      = o_x;
    y_nxt      = o_y;
    colour_nxt = o_colour;
    z_nxt      = o_z;

    case (state)
      S_IDLE: begin
        if (i_start) begin
          state_nxt = S_SETUP;
          v1_nxt    = i_v1;
          v2_nxt    = i_v2;
          v3_nxt    = i_v3;
          c1_nxt    = i_c1;
          c2_nxt    = i_c2;
          c3_nxt    = i_c3;
        end
      end
      S_SETUP: begin
        if (box_empty || cull) begin
          state_nxt = S_DONE;
        end else begin
          state_nxt = S_SCAN;
          xmin_nxt  = bx_lo;
          xmax_nxt  = bx_hi;
          ymax_nxt  = by_hi;
          px_x_nxt  = bx_lo;
          px_y_nxt  = by_lo;
        end
      end
      S_SCAN: begin
        if (slot_free) begin
          if (i_px_write) begin
            valid_nxt  = 1'b1;
            x_nxt      = o_px_x;
            y_nxt      = o_px_y;
            colour_nxt = i_px_colour;
            z_nxt      = i_px_z;
          end else begin
            valid_nxt  = 1'b0;
          end
          if (o_px_x == xmax) begin
            if (o_px_y == ymax) begin
              state_nxt = S_DRAIN;
            end else begin
              px_x_nxt  = xmin;
              px_y_nxt  = o_px_y + 32'sd1;
            end
          end else begin
            px_x_nxt = o_px_x + 32'sd1;
          end
        end
      end
      S_DRAIN: begin
        if (slot_free) begin
          valid_nxt = 1'b0;
          state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
        valid_nxt = 1'b0;
      end
    endcase

    busy_nxt = (state_nxt != S_IDLE);
    done_nxt = (state_nxt == S_DONE);
  end

  // State and registered outputs; synchronous active-low reset.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state    <= S_IDLE;
      o_v1     <= '0;
      o_v2     <= '0;
      o_v3     <= '0;
      o_c1     <= '0;
      o_c2     <= '0;
      o_c3     <= '0;
      xmin     <= '0;
      xmax     <= '0;
      ymax     <= '0;
      o_px_x   <= '0;
      o_px_y   <= '0;
      o_valid  <= 1'b0;
      o_x      <= '0;
      o_y      <= '0;
      o_colour <= '0;
      o_z      <= '0;
      o_busy   <= 1'b0;
      o_done   <= 1'b0;
    end else begin
      state    <= state_nxt;
      o_v1     <= v1_nxt;
      o_v2     <= v2_nxt;
      o_v3     <= v3_nxt;
      o_c1     <= c1_nxt;
      o_c2     <= c2_nxt;
      o_c3     <= c3_nxt;
      xmin     <= xmin_nxt;
      xmax     <= xmax_nxt;
      ymax     <= ymax_nxt;
      o_px_x   <= px_x_nxt;
      o_px_y   <= px_y_nxt;
      o_valid  <= valid_nxt;
      o_x      <= x_nxt;
      o_y      <= y_nxt;
      o_colour <= colour_nxt;
      o_z      <= z_nxt;
      o_busy   <= busy_nxt;
      o_done   <= done_nxt;
    end
  end

endmodule
